// File: rtl/sb_stream_xform.sv
// sb_stream_xform: registered add-constant stage with a 2-entry skid buffer.
// Adds ADD_VAL to the low ADD_W bits of each beat, passes dest/last/upper data
// through, and swallows the all-ones terminator beat (raising sticky done).
// Optional feature macro: SB_STREAM_XFORM_STATS_EN adds beat/packet/stall counters.
//
// Handshake rule (both sides): a beat moves on a cycle where valid && ready.
// out_valid is decoded from the state register and in_ready is its own flop,
// so neither valid nor ready depends combinationally on the other side.
// The buffer state is exposed on 'state' (EMPTY=0, ONE=1, FULL=2).
module sb_stream_xform #(
    parameter int unsigned DW      = 256,
    parameter int unsigned DESTW   = 32,
    parameter int unsigned ADD_W   = 64,
    parameter int unsigned ADD_VAL = 42
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic [DESTW-1:0] in_dest,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic [DESTW-1:0] out_dest,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       state,
    output logic             done
`ifdef SB_STREAM_XFORM_STATS_EN
    ,
    output logic [31:0]      beat_cnt,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [DESTW-1:0] dest;
        logic             last;
    } beat_t;

    buf_state_t cur_state;
    buf_state_t nxt_state;

    beat_t new_beat;
    beat_t out_reg;
    beat_t skid_reg;

    logic accept;
    logic is_term;
    logic load;
    logic out_fire;
    logic load_out;
    logic load_skid;
    logic skid_to_out;
    logic term_seen;

    // Low field wraps modulo 2^ADD_W; the carry out is simply dropped.
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        r[ADD_W-1:0] = d[ADD_W-1:0] + ADD_W'(ADD_VAL);
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign is_term   = &in_data;
    // The terminator is consumed here and never enters the buffer.
    assign load      = accept && !is_term;
    assign term_seen = accept && is_term;
    assign out_valid = (cur_state != EMPTY);
    assign out_fire  = out_valid && out_ready;
    assign new_beat  = {xform(in_data), in_dest, in_last};

    assign out_data  = out_reg.data;
    assign out_dest  = out_reg.dest;
    assign out_last  = out_reg.last;
    assign state     = cur_state;

    // Next-state and buffer load controls.
    always_comb begin
        nxt_state   = cur_state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (cur_state)
            EMPTY: begin
                if (load) begin
                    nxt_state = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (load && !out_ready) begin
                    nxt_state = FULL;
                    load_skid = 1'b1;
                end else if (load && out_ready) begin
                    load_out  = 1'b1;
                end else if (out_ready) begin
                    nxt_state = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    nxt_state   = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: nxt_state = EMPTY;
        endcase
    end

    // State, registered in_ready and the sticky done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= EMPTY;
            in_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            done      <= done || term_seen;
            in_ready  <= (nxt_state != FULL) && !(done || term_seen);
        end
    end

    // Output and skid registers; the skid entry always drains into the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            if (load_out) begin
                out_reg <= new_beat;
            end else if (skid_to_out) begin
                out_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= new_beat;
            end
        end
    end

`ifdef SB_STREAM_XFORM_STATS_EN
    // Transfer, packet and stall counters; the terminator never reaches out_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_fire) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (out_fire && out_last) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sb_stream_xform.sv
// Testbench for sb_stream_xform: directed stimulus, a queue-based reference
// model of the stream, and literal expectations for key cases.
module tb_sb_stream_xform;

    localparam int DW    = 256;
    localparam int DESTW = 32;
    localparam int CW    = DW + DESTW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0]    in_data;
    logic [DESTW-1:0] in_dest;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    out_data;
    logic [DESTW-1:0] out_dest;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       state;
    logic             done;
`ifdef SB_STREAM_XFORM_STATS_EN
    logic [31:0]      beat_cnt;
    logic [31:0]      pkt_cnt;
    logic [31:0]      stall_cnt;
`endif

    sb_stream_xform dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (state),
        .done      (done)
`ifdef SB_STREAM_XFORM_STATS_EN
        ,
        .beat_cnt  (beat_cnt),
        .pkt_cnt   (pkt_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fires  = 0;
    int lasts  = 0;

    logic [CW-1:0] exp_q[$];
    logic [63:0]   fired_low[$];
    logic          exp_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference transform: low 64 bits plus 42 modulo 2^64, upper bits kept.
    function automatic logic [DW-1:0] model_xform(input logic [DW-1:0] d);
        logic [63:0] lo;
        lo = d[63:0] + 64'd42;
        return {d[DW-1:64], lo};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            check("mon_out_valid", CW'(out_valid), CW'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("mon_beat", {out_data, out_dest, out_last}, exp_q[0]);
            end
            check("mon_done", CW'(done), CW'(exp_done));
            if (exp_done) begin
                check("mon_in_ready_after_done", CW'(in_ready), CW'(0));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                fires++;
                if (out_last) lasts++;
                fired_low.push_back(out_data[63:0]);
            end
            if (in_valid && in_ready) begin
                if (&in_data) exp_done = 1'b1;
                else exp_q.push_back({model_xform(in_data), in_dest, in_last});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DESTW-1:0] dst, input logic l);
        int waited;
        waited   = 0;
        in_data  = d;
        in_dest  = dst;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("send_accept_timeout", CW'(in_ready), CW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int c0;
        int f0;
        int l0;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", CW'(out_valid), CW'(0));
        check("rst_in_ready", CW'(in_ready), CW'(0));
        check("rst_done", CW'(done), CW'(0));
        check("rst_state", CW'(state), CW'(0));
        check("rst_out_data", CW'(out_data), CW'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_before_first_edge", CW'(in_ready), CW'(0));
        @(negedge clk);
        check("in_ready_after_release", CW'(in_ready), CW'(1));
        step();

        // 1: single beat
        out_ready = 1'b1;
        send_beat(DW'(1), 32'd5, 1'b1);
        @(negedge clk);
        check("t1_out_data", CW'(out_data), CW'(43));
        check("t1_out_dest", CW'(out_dest), CW'(5));
        check("t1_out_last", CW'(out_last), CW'(1));
        @(negedge clk);
        check("t1_state_empty", CW'(state), CW'(0));
        step();

        // 2: 100 back-to-back beats at full rate
        c0 = cyc;
        f0 = fires;
        for (int i = 0; i < 100; i++) begin
            d = {192'(i * 7 + 1), 64'(i * 1000003)};
            send_beat(d, 32'(i), (i % 10) == 9);
        end
        check("t2_accept_cycles", CW'(cyc - c0), CW'(100));
        repeat (3) step();
        check("t2_output_count", CW'(fires - f0), CW'(100));

        // 3: backpressure fills both entries
        out_ready = 1'b0;
        f0 = fires;
        send_beat(DW'(10), 32'd1, 1'b0);
        send_beat(DW'(11), 32'd2, 1'b0);
        in_data  = DW'(12);
        in_dest  = 32'd3;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("t3_in_ready_full", CW'(in_ready), CW'(0));
        check("t3_state_full", CW'(state), CW'(2));
        check("t3_head_data", CW'(out_data), CW'(52));
        repeat (2) @(negedge clk);
        check("t3_none_emitted", CW'(fires - f0), CW'(0));
        step();
        out_ready = 1'b1;
        send_beat(DW'(12), 32'd3, 1'b1);
        repeat (3) step();
        check("t3_emitted", CW'(fires - f0), CW'(3));
        check("t3_order_a", CW'(fired_low[fired_low.size() - 3]), CW'(52));
        check("t3_order_b", CW'(fired_low[fired_low.size() - 2]), CW'(53));
        check("t3_order_c", CW'(fired_low[fired_low.size() - 1]), CW'(54));

        // 4: low-field wrap, upper bits untouched
        d     = {{24{8'hA5}}, 64'hFFFF_FFFF_FFFF_FFF0};
        exp_d = {{24{8'hA5}}, 64'h0000_0000_0000_001A};
        send_beat(d, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("t4_wrap", CW'(out_data), CW'(exp_d));
        step();

        // 5: terminator consumed, done sticky
        f0 = fires;
        send_beat(DW'(7), 32'd0, 1'b0);
        send_beat(DW'(8), 32'd0, 1'b1);
        send_beat('1, 32'd0, 1'b1);
        in_data  = DW'(9);
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t5_done", CW'(done), CW'(1));
            check("t5_in_ready_low", CW'(in_ready), CW'(0));
        end
        step();
        in_valid = 1'b0;
        check("t5_output_count", CW'(fires - f0), CW'(2));
        check("t5_first", CW'(fired_low[fired_low.size() - 2]), CW'(49));
        check("t5_second", CW'(fired_low[fired_low.size() - 1]), CW'(50));

        // 6: reset while FULL discards everything
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b0;
        send_beat(DW'(20), 32'd1, 1'b0);
        send_beat(DW'(21), 32'd1, 1'b1);
        @(negedge clk);
        check("t6_state_full", CW'(state), CW'(2));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid", CW'(out_valid), CW'(0));
        check("t6_state", CW'(state), CW'(0));
        check("t6_done", CW'(done), CW'(0));
        check("t6_in_ready", CW'(in_ready), CW'(0));
`ifdef SB_STREAM_XFORM_STATS_EN
        check("t6_beat_cnt", CW'(beat_cnt), CW'(0));
        check("t6_pkt_cnt", CW'(pkt_cnt), CW'(0));
        check("t6_stall_cnt", CW'(stall_cnt), CW'(0));
`endif
        out_ready = 1'b1;
        f0 = fires;
        repeat (5) @(negedge clk);
        check("t6_nothing_emitted", CW'(fires - f0), CW'(0));
        step();

        // 6b: 4 packets of 3 beats
        f0 = fires;
        l0 = lasts;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 3; b++) begin
                send_beat(DW'(p * 3 + b + 100), 32'(p), b == 2);
            end
        end
        repeat (3) step();
        check("t6b_beats", CW'(fires - f0), CW'(12));
        check("t6b_pkts", CW'(lasts - l0), CW'(4));
`ifdef SB_STREAM_XFORM_STATS_EN
        check("t6b_beat_cnt", CW'(beat_cnt), CW'(12));
        check("t6b_pkt_cnt", CW'(pkt_cnt), CW'(4));
        check("t6b_stall_cnt", CW'(stall_cnt), CW'(0));
`endif

        // Stall cycles under backpressure
        out_ready = 1'b0;
        send_beat(DW'(200), 32'd9, 1'b1);
        repeat (3) step();
`ifdef SB_STREAM_XFORM_STATS_EN
        check("stall_cnt_3", CW'(stall_cnt), CW'(3));
`endif
        check("stall_held_valid", CW'(out_valid), CW'(1));
        check("stall_held_data", CW'(out_data), CW'(242));
        out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
